// File: rtl/fft_frame_sequencer.sv
// Frame-level load/unload controller for an in-place CoreFFT with a streaming front and back end.
// Optional frame statistics counters are built only when FFT_SEQ_STATS_EN is defined.
module fft_frame_sequencer #(
  parameter int WIDTH  = 10,
  parameter int POINTS = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sValid,
  output logic               sReady,
  input  logic [2*WIDTH-1:0] sData,
  input  logic               fftBufReady,
  output logic               fftDataiValid,
  output logic [2*WIDTH-1:0] fftDatai,
  input  logic               fftOutpReady,
  output logic               fftReadOutp,
  input  logic               fftDataoValid,
  input  logic [2*WIDTH-1:0] fftDatao,
  output logic               mValid,
  output logic [2*WIDTH-1:0] mData,
  output logic               mLast,
  input  logic               mReady,
  output logic [2:0]         frameErr,
  input  logic               errClr,
  output logic [15:0]        framesIn,
  output logic [15:0]        framesOut
);

  localparam int CW = $clog2(POINTS) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(POINTS - 1);

  typedef enum logic {
    LOAD     = 1'b0,
    WAIT_BUF = 1'b1
  } InState;

  typedef enum logic [1:0] {
    O_IDLE = 2'd0,
    O_READ = 2'd1,
    O_WAIT = 2'd2
  } OutState;

  InState        inState, inStateNext;
  OutState       outState, outStateNext;
  logic [CW-1:0] inCnt, inCntNext;
  logic [CW-1:0] outCnt, outCntNext;
  logic          readOutpNext;
  logic          sAccept;
  logic          errAbort, errShort, errDrop;
  logic [2:0]    frameErrNext;

  // Handshake: a sample transfers on any cycle with sValid & sReady; sReady never depends on sValid.
  // The output side has no per-sample backpressure: mReady is only sampled to start an unload.
  assign sReady        = ~reset & (inState == LOAD) & fftBufReady;
  assign sAccept       = sValid & sReady;
  assign fftDataiValid = sAccept;
  assign fftDatai      = reset ? '0 : sData;

  // Input FSM: count accepted samples; a buffer pulled away mid-frame aborts the partial frame.
  always_comb begin
    inStateNext = inState;
    inCntNext   = inCnt;
    errAbort    = 1'b0;
    unique case (inState)
      LOAD: begin
        if (sAccept) begin
          if (inCnt == LAST_IDX) begin
            inStateNext = WAIT_BUF;
            inCntNext   = '0;
          end else begin
            inCntNext = inCnt + 1'b1;
          end
        end else if (!fftBufReady && (inCnt != '0)) begin
          errAbort  = 1'b1;
          inCntNext = '0;
        end
      end
      WAIT_BUF: begin
        if (!fftBufReady) inStateNext = LOAD;
      end
      default: begin
        inStateNext = LOAD;
        inCntNext   = '0;
      end
    endcase
  end

  // Output FSM: READ_OUTP is registered, so it rises the cycle after the unload is granted.
  always_comb begin
    outStateNext = outState;
    outCntNext   = outCnt;
    readOutpNext = fftReadOutp;
    errShort     = 1'b0;
    unique case (outState)
      O_IDLE: begin
        if (fftOutpReady && mReady) begin
          outStateNext = O_READ;
          readOutpNext = 1'b1;
        end
      end
      O_READ: begin
        if (fftDataoValid && (outCnt == LAST_IDX)) begin
          outStateNext = O_WAIT;
          readOutpNext = 1'b0;
        end else if (!fftOutpReady) begin
          errShort     = 1'b1;
          outStateNext = O_IDLE;
          readOutpNext = 1'b0;
          outCntNext   = '0;
        end else if (fftDataoValid) begin
          outCntNext = outCnt + 1'b1;
        end
      end
      O_WAIT: begin
        if (!fftOutpReady) begin
          outStateNext = O_IDLE;
          outCntNext   = '0;
        end
      end
      default: begin
        outStateNext = O_IDLE;
        outCntNext   = '0;
        readOutpNext = 1'b0;
      end
    endcase
  end

  // A registered sample the sink was not ready for is lost.
  assign errDrop      = mValid & ~mReady;
  assign frameErrNext = (errClr ? 3'b000 : frameErr) | {errDrop, errShort, errAbort};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inState     <= LOAD;
      inCnt       <= '0;
      outState    <= O_IDLE;
      outCnt      <= '0;
      fftReadOutp <= 1'b0;
      frameErr    <= 3'b000;
    end else begin
      inState     <= inStateNext;
      inCnt       <= inCntNext;
      outState    <= outStateNext;
      outCnt      <= outCntNext;
      fftReadOutp <= readOutpNext;
      frameErr    <= frameErrNext;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mValid <= 1'b0;
      mData  <= '0;
      mLast  <= 1'b0;
    end else begin
      mValid <= fftDataoValid & (outState == O_READ);
      mLast  <= fftDataoValid & (outState == O_READ) & (outCnt == LAST_IDX);
      if (fftDataoValid && (outState == O_READ)) mData <= fftDatao;
    end
  end

`ifdef FFT_SEQ_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      framesIn  <= 16'h0000;
      framesOut <= 16'h0000;
    end else begin
      if ((inState == LOAD) && (inStateNext == WAIT_BUF)) framesIn <= framesIn + 16'h0001;
      if (mLast && mValid) framesOut <= framesOut + 16'h0001;
    end
  end
`else
  assign framesIn  = 16'h0000;
  assign framesOut = 16'h0000;
`endif

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer (WIDTH=10, POINTS=32) with an expected-data queue for outputs.
module tb_fft_frame_sequencer;

  localparam int WIDTH  = 10;
  localparam int POINTS = 32;
  localparam int DW     = 2 * WIDTH;
`ifdef FFT_SEQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sValid = 1'b0;
  logic          sReady;
  logic [DW-1:0] sData = '0;
  logic          fftBufReady = 1'b1;
  logic          fftDataiValid;
  logic [DW-1:0] fftDatai;
  logic          fftOutpReady = 1'b0;
  logic          fftReadOutp;
  logic          fftDataoValid = 1'b0;
  logic [DW-1:0] fftDatao = '0;
  logic          mValid;
  logic [DW-1:0] mData;
  logic          mLast;
  logic          mReady = 1'b0;
  logic [2:0]    frameErr;
  logic          errClr = 1'b0;
  logic [15:0]   framesIn;
  logic [15:0]   framesOut;

  int checks = 0;
  int errors = 0;
  int outs = 0;
  int lasts = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_d;

  fft_frame_sequencer #(.WIDTH(WIDTH), .POINTS(POINTS)) dut (
    .clk(clk), .reset(reset),
    .sValid(sValid), .sReady(sReady), .sData(sData),
    .fftBufReady(fftBufReady), .fftDataiValid(fftDataiValid), .fftDatai(fftDatai),
    .fftOutpReady(fftOutpReady), .fftReadOutp(fftReadOutp),
    .fftDataoValid(fftDataoValid), .fftDatao(fftDatao),
    .mValid(mValid), .mData(mData), .mLast(mLast), .mReady(mReady),
    .frameErr(frameErr), .errClr(errClr),
    .framesIn(framesIn), .framesOut(framesOut)
  );

  // clock/reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_samples(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      sValid = 1'b1;
      sData  = DW'(base + i);
      #1;
      check_eq("datai_valid", 32'(fftDataiValid), 32'd1);
      check_eq("datai", 32'(fftDatai), 32'(DW'(base + i)));
      tick();
    end
    sValid = 1'b0;
  endtask

  // Drive one core output sample, then check the registered stream sample against the queue.
  task automatic core_emit(input logic [DW-1:0] d, input bit is_last);
    fftDataoValid = 1'b1;
    fftDatao      = d;
    exp_q.push_back(d);
    tick();
    check_eq("m_valid", 32'(mValid), 32'd1);
    if (exp_q.size() > 0) begin
      exp_d = exp_q.pop_front();
      check_eq("m_data", 32'(mData), 32'(exp_d));
    end
    check_eq("m_last", 32'(mLast), 32'(is_last));
    if (mValid) outs++;
    if (mValid && mLast) lasts++;
  endtask

  initial begin
    // 1: reset state with buffer ready and a valid offered
    sValid = 1'b1;
    tick();
    tick();
    check_eq("rst_s_ready", 32'(sReady), 32'd0);
    check_eq("rst_datai_valid", 32'(fftDataiValid), 32'd0);
    check_eq("rst_read_outp", 32'(fftReadOutp), 32'd0);
    check_eq("rst_m_valid", 32'(mValid), 32'd0);
    check_eq("rst_m_last", 32'(mLast), 32'd0);
    check_eq("rst_frame_err", 32'(frameErr), 32'd0);
    check_eq("rst_frames_in", 32'(framesIn), 32'd0);
    sValid = 1'b0;
    reset  = 1'b0;
    tick();
    check_eq("s_ready_after_rst", 32'(sReady), 32'd1);
    check_eq("frame_err_after_rst", 32'(frameErr), 32'd0);

    // 2: one full frame, then the input stalls until the core takes the buffer
    load_samples(32, 0);
    sValid = 1'b1;
    #1;
    check_eq("wait_buf_s_ready", 32'(sReady), 32'd0);
    check_eq("wait_buf_datai_valid", 32'(fftDataiValid), 32'd0);
    sValid = 1'b0;
    tick();
    check_eq("wait_buf_hold", 32'(sReady), 32'd0);
    fftBufReady = 1'b0;
    tick();
    fftBufReady = 1'b1;
    #1;
    check_eq("reload_s_ready", 32'(sReady), 32'd1);
    check_eq("frames_in_1", 32'(framesIn), STATS ? 32'd1 : 32'd0);

    // 3: full unload
    fftOutpReady = 1'b1;
    mReady       = 1'b1;
    #1;
    check_eq("read_outp_not_yet", 32'(fftReadOutp), 32'd0);
    tick();
    check_eq("read_outp_rise", 32'(fftReadOutp), 32'd1);
    for (int k = 0; k < POINTS; k++) core_emit(DW'(k * 3 + 5), k == POINTS - 1);
    check_eq("read_outp_fall", 32'(fftReadOutp), 32'd0);
    fftDataoValid = 1'b0;
    fftOutpReady  = 1'b0;
    tick();
    check_eq("m_valid_end", 32'(mValid), 32'd0);
    check_eq("unload_frame_err", 32'(frameErr), 32'd0);
    check_eq("frames_out_1", 32'(framesOut), STATS ? 32'd1 : 32'd0);

    // 4: aborted load, then a full frame counted from zero, then clear
    load_samples(10, 200);
    fftBufReady = 1'b0;
    tick();
    check_eq("abort_err", 32'(frameErr), 32'b001);
    fftBufReady = 1'b1;
    load_samples(32, 300);
    sValid = 1'b1;
    #1;
    check_eq("after_abort_full", 32'(sReady), 32'd0);
    sValid      = 1'b0;
    fftBufReady = 1'b0;
    tick();
    fftBufReady = 1'b1;
    errClr      = 1'b1;
    tick();
    errClr = 1'b0;
    check_eq("err_clr", 32'(frameErr), 32'd0);
    check_eq("frames_in_2", 32'(framesIn), STATS ? 32'd2 : 32'd0);

    // 5: short output frame, then a dropped sample with a clear on the same cycle
    fftOutpReady = 1'b1;
    mReady       = 1'b1;
    tick();
    for (int k = 0; k < 20; k++) core_emit(DW'(k + 40), 1'b0);
    fftDataoValid = 1'b0;
    fftOutpReady  = 1'b0;
    tick();
    check_eq("short_err", 32'(frameErr), 32'b010);
    check_eq("short_read_outp", 32'(fftReadOutp), 32'd0);
    fftOutpReady = 1'b1;
    tick();
    mReady        = 1'b0;
    fftDataoValid = 1'b1;
    fftDatao      = DW'(77);
    tick();
    check_eq("drop_m_valid", 32'(mValid), 32'd1);
    fftDataoValid = 1'b0;
    errClr        = 1'b1;
    tick();
    check_eq("drop_err_set_priority", 32'(frameErr), 32'b100);
    errClr       = 1'b0;
    fftOutpReady = 1'b0;
    mReady       = 1'b1;
    tick();
    check_eq("drop_then_short", 32'(frameErr), 32'b110);
    errClr = 1'b1;
    tick();
    errClr = 1'b0;
    check_eq("err_clr_2", 32'(frameErr), 32'd0);
    check_eq("frames_out_after_short", 32'(framesOut), STATS ? 32'd1 : 32'd0);

    // 6: four frames with load and unload running in the same cycles
    outs  = 0;
    lasts = 0;
    for (int f = 0; f < 4; f++) begin
      fftBufReady  = 1'b1;
      fftOutpReady = 1'b1;
      mReady       = 1'b1;
      tick();
      for (int i = 0; i < POINTS; i++) begin
        sValid = 1'b1;
        sData  = DW'(f * 32 + i);
        #1;
        check_eq("ovl_datai_valid", 32'(fftDataiValid), 32'd1);
        core_emit(DW'(1000 + f * 32 + i), i == POINTS - 1);
      end
      sValid        = 1'b0;
      fftDataoValid = 1'b0;
      fftBufReady   = 1'b0;
      fftOutpReady  = 1'b0;
      tick();
    end
    check_eq("ovl_outputs", 32'(outs), 32'd128);
    check_eq("ovl_lasts", 32'(lasts), 32'd4);
    check_eq("ovl_frame_err", 32'(frameErr), 32'd0);
    check_eq("frames_in_6", 32'(framesIn), STATS ? 32'd6 : 32'd0);
    check_eq("frames_out_5", 32'(framesOut), STATS ? 32'd5 : 32'd0);

    // reset in the middle of a load and an unload
    fftBufReady = 1'b1;
    load_samples(5, 500);
    fftOutpReady = 1'b1;
    tick();
    fftDataoValid = 1'b1;
    fftDatao      = DW'(9);
    tick();
    check_eq("pre_rst_m_valid", 32'(mValid), 32'd1);
    sValid = 1'b1;
    reset  = 1'b1;
    #1;
    check_eq("mid_rst_s_ready", 32'(sReady), 32'd0);
    check_eq("mid_rst_read_outp", 32'(fftReadOutp), 32'd0);
    check_eq("mid_rst_m_valid", 32'(mValid), 32'd0);
    check_eq("mid_rst_datai_valid", 32'(fftDataiValid), 32'd0);
    sValid        = 1'b0;
    fftDataoValid = 1'b0;
    fftOutpReady  = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check_eq("post_rst_s_ready", 32'(sReady), 32'd1);
    check_eq("post_rst_frames_in", 32'(framesIn), 32'd0);
    load_samples(32, 600);
    sValid = 1'b1;
    #1;
    check_eq("post_rst_full", 32'(sReady), 32'd0);
    sValid = 1'b0;
    check_eq("post_rst_frames_in_1", 32'(framesIn), STATS ? 32'd1 : 32'd0);
    check_eq("post_rst_frame_err", 32'(frameErr), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
